// File: rtl/p03_clock_pkg.sv
// Shared definitions for the VGA clock timekeeping slice: mode encoding,
// digit widths, default prescaler length and the 12-hour display helper.
package p03_clock_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_SET_HRS = 2'd1,
    MODE_SET_MIN = 2'd2,
    MODE_SET_SEC = 2'd3
  } mode_e;

  localparam int HRS_D_W = 2;
  localparam int MIN_D_W = 3;
  localparam int SEC_D_W = 3;
  localparam int UNIT_W  = 4;

  localparam int DEFAULT_TICKS_PER_SEC = 31_500_000;

  typedef struct packed {
    logic [HRS_D_W-1:0] d;
    logic [UNIT_W-1:0]  u;
    logic               pm;
  } hour12_t;

  // Map an internal 00..23 BCD hour onto the 12,01..11 display plus pm flag.
  function automatic hour12_t to_12h(input logic [HRS_D_W-1:0] d,
                                     input logic [UNIT_W-1:0]  u);
    hour12_t r;
    int      h;
    h    = int'(d) * 10 + int'(u);
    r.pm = (h >= 12);
    h    = h % 12;
    if (h == 0) h = 12;
    r.d  = HRS_D_W'(h / 10);
    r.u  = UNIT_W'(h % 10);
    return r;
  endfunction

endpackage

// File: rtl/p03_time_set_ctrl_if.sv
// Button/frame strobes in, time digits and display control out.
// With TWELVE_HOUR_EN defined the bundle also carries the pm flag.
interface p03_time_set_ctrl_if;
  import p03_clock_pkg::*;

  logic               frame_start;
  logic               mode_pulse;
  logic               inc_pulse;
  logic [HRS_D_W-1:0] hrs_d;
  logic [UNIT_W-1:0]  hrs_u;
  logic [MIN_D_W-1:0] min_d;
  logic [UNIT_W-1:0]  min_u;
  logic [SEC_D_W-1:0] sec_d;
  logic [UNIT_W-1:0]  sec_u;
  logic [2:0]         blank_mask;
  logic [1:0]         mode;
  logic               minute_tick;
`ifdef TWELVE_HOUR_EN
  logic               pm;
`endif

  // Pulse source / display consumer side.
  modport master (
    output frame_start, mode_pulse, inc_pulse,
    input  hrs_d, hrs_u, min_d, min_u, sec_d, sec_u,
    input  blank_mask, mode, minute_tick
`ifdef TWELVE_HOUR_EN
    , input pm
`endif
  );

  // Controller side.
  modport slave (
    input  frame_start, mode_pulse, inc_pulse,
    output hrs_d, hrs_u, min_d, min_u, sec_d, sec_u,
    output blank_mask, mode, minute_tick
`ifdef TWELVE_HOUR_EN
    , output pm
`endif
  );

endinterface

// File: rtl/p03_bcd_pair.sv
// Two-digit BCD counter wrapping at MODULUS (24 or 60). carry_out is
// combinational so a chain of pairs resolves every carry in one cycle.
module p03_bcd_pair #(
  parameter int MODULUS = 60,
  parameter int TENS_W  = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inc,
  input  logic              clr,
  output logic [TENS_W-1:0] tens,
  output logic [3:0]        units,
  output logic              carry_out
);

  localparam logic [TENS_W-1:0] TENS_MAX  = TENS_W'((MODULUS - 1) / 10);
  localparam logic [3:0]        UNITS_MAX = 4'((MODULUS - 1) % 10);

  logic at_max;

  assign at_max    = (tens == TENS_MAX) && (units == UNITS_MAX);
  assign carry_out = inc && !clr && at_max;

  // Count register: clear beats increment; wrap at the modulus.
  // NOTE: state is updated with <= so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tens  <= '0;
      units <= '0;
    end else if (clr) begin
      tens  <= '0;
      units <= '0;
    end else if (inc) begin
      if (at_max) begin
        tens  <= '0;
        units <= '0;
      end else if (units == 4'd9) begin
        tens  <= tens + 1'b1;
        units <= '0;
      end else begin
        units <= units + 1'b1;
      end
    end
  end

endmodule

// File: rtl/p03_time_set_ctrl.sv
// Timekeeping and time-set controller for the VGA clock: 1 Hz prescaler,
// HH:MM:SS BCD registers, mode FSM for setting the time, blink mask for the
// field being edited, edit timeout and a minute strobe.
// Optional macro TWELVE_HOUR_EN: 12-hour hour display plus a pm output.
module p03_time_set_ctrl
  import p03_clock_pkg::*;
#(
  parameter int TICKS_PER_SEC  = DEFAULT_TICKS_PER_SEC,
  parameter int BLINK_FRAMES   = 18,
  parameter int TIMEOUT_FRAMES = 700
) (
  input logic                clk,
  input logic                reset,
  p03_time_set_ctrl_if.slave bus
);

  localparam int PW = (TICKS_PER_SEC  > 1) ? $clog2(TICKS_PER_SEC)  : 1;
  localparam int BW = (BLINK_FRAMES   > 1) ? $clog2(BLINK_FRAMES)   : 1;
  localparam int TW = (TIMEOUT_FRAMES > 1) ? $clog2(TIMEOUT_FRAMES) : 1;

  localparam logic [PW-1:0] PRESC_MAX   = PW'(TICKS_PER_SEC - 1);
  localparam logic [BW-1:0] BLINK_MAX   = BW'(BLINK_FRAMES - 1);
  localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_FRAMES - 1);

  mode_e              state_q, state_d;
  logic [PW-1:0]      presc_q;
  logic [TW-1:0]      timeout_q;
  logic [BW-1:0]      blink_cnt_q, blink_cnt_d;
  logic               blink_ph_q, blink_ph_d;
  logic [2:0]         blank_mask_q, blank_mask_d;
  logic               minute_tick_q;

  logic               in_run, inc_eff, entry, sec_tick, timeout_hit;
  logic               sec_inc, sec_clr, min_inc, hrs_inc;
  logic               sec_carry, min_carry, day_wrap_unused;
  logic [HRS_D_W-1:0] hrs_tens;
  logic [UNIT_W-1:0]  hrs_units;
  logic [MIN_D_W-1:0] min_tens;
  logic [UNIT_W-1:0]  min_units;
  logic [SEC_D_W-1:0] sec_tens;
  logic [UNIT_W-1:0]  sec_units;

  assign in_run      = (state_q == MODE_RUN);
  // A mode press in the same cycle swallows the increment.
  assign inc_eff     = bus.inc_pulse && !bus.mode_pulse;
  assign sec_tick    = in_run && (presc_q == PRESC_MAX);
  assign timeout_hit = !in_run && bus.frame_start && (timeout_q == TIMEOUT_MAX);
  assign entry       = (state_d != state_q);

  // Field increments: carries only ripple while running; SET_MIN never
  // carries into hours.
  assign sec_inc = sec_tick;
  assign sec_clr = (state_q == MODE_SET_SEC) && inc_eff;
  assign min_inc = (in_run && sec_carry) || ((state_q == MODE_SET_MIN) && inc_eff);
  assign hrs_inc = (in_run && min_carry) || ((state_q == MODE_SET_HRS) && inc_eff);

  // Mode FSM next state: mode press steps the cycle, idle timeout exits to RUN.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    if (bus.mode_pulse) begin
      case (state_q)
        MODE_RUN:     state_d = MODE_SET_HRS;
        MODE_SET_HRS: state_d = MODE_SET_MIN;
        MODE_SET_MIN: state_d = MODE_SET_SEC;
        MODE_SET_SEC: state_d = MODE_RUN;
        default:      state_d = MODE_RUN;
      endcase
    end else if (timeout_hit) begin
      state_d = MODE_RUN;
    end
  end

  // Blink phase: toggles every BLINK_FRAMES frames, forced visible on edits.
  always_comb begin
    blink_cnt_d = blink_cnt_q;
    blink_ph_d  = blink_ph_q;
    if (bus.inc_pulse || entry) begin
      blink_cnt_d = '0;
      blink_ph_d  = 1'b0;
    end else if (bus.frame_start) begin
      if (blink_cnt_q == BLINK_MAX) begin
        blink_cnt_d = '0;
        blink_ph_d  = !blink_ph_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Blank mask derived from next-cycle state so it lines up with mode output.
  always_comb begin
    blank_mask_d = 3'b000;
    if (blink_ph_d) begin
      case (state_d)
        MODE_SET_HRS: blank_mask_d = 3'b100;
        MODE_SET_MIN: blank_mask_d = 3'b010;
        MODE_SET_SEC: blank_mask_d = 3'b001;
        default:      blank_mask_d = 3'b000;
      endcase
    end
  end

  // State, blink and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= MODE_RUN;
      blink_cnt_q   <= '0;
      blink_ph_q    <= 1'b0;
      blank_mask_q  <= 3'b000;
      minute_tick_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_ph_q    <= blink_ph_d;
      blank_mask_q  <= blank_mask_d;
      minute_tick_q <= min_inc;
    end
  end

  // Prescaler: free-runs in RUN, held while editing, zeroed by SET_SEC inc.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc_q <= '0;
    end else if (in_run) begin
      presc_q <= sec_tick ? '0 : presc_q + 1'b1;
    end else if (sec_clr) begin
      presc_q <= '0;
    end
  end

  // Edit timeout: counts frames in SET states, restarted by any button or entry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= '0;
    end else if (bus.mode_pulse || bus.inc_pulse || entry) begin
      timeout_q <= '0;
    end else if (!in_run && bus.frame_start) begin
      timeout_q <= timeout_q + 1'b1;
    end
  end

  p03_bcd_pair #(.MODULUS(60), .TENS_W(SEC_D_W)) u_sec (
    .clk       (clk),
    .reset     (reset),
    .inc       (sec_inc),
    .clr       (sec_clr),
    .tens      (sec_tens),
    .units     (sec_units),
    .carry_out (sec_carry)
  );

  p03_bcd_pair #(.MODULUS(60), .TENS_W(MIN_D_W)) u_min (
    .clk       (clk),
    .reset     (reset),
    .inc       (min_inc),
    .clr       (1'b0),
    .tens      (min_tens),
    .units     (min_units),
    .carry_out (min_carry)
  );

  p03_bcd_pair #(.MODULUS(24), .TENS_W(HRS_D_W)) u_hrs (
    .clk       (clk),
    .reset     (reset),
    .inc       (hrs_inc),
    .clr       (1'b0),
    .tens      (hrs_tens),
    .units     (hrs_units),
    .carry_out (day_wrap_unused)
  );

`ifdef TWELVE_HOUR_EN
  // Display remap only; counting stays 24-hour internally.
  hour12_t hrs12;
  assign hrs12     = to_12h(hrs_tens, hrs_units);
  assign bus.hrs_d = hrs12.d;
  assign bus.hrs_u = hrs12.u;
  assign bus.pm    = hrs12.pm;
`else
  assign bus.hrs_d = hrs_tens;
  assign bus.hrs_u = hrs_units;
`endif

  assign bus.min_d       = min_tens;
  assign bus.min_u       = min_units;
  assign bus.sec_d       = sec_tens;
  assign bus.sec_u       = sec_units;
  assign bus.blank_mask  = blank_mask_q;
  assign bus.mode        = state_q;
  assign bus.minute_tick = minute_tick_q;

endmodule

// File: tb/tb_p03_time_set_ctrl.sv
// Self-checking bench for p03_time_set_ctrl: directed scenarios followed by
// randomized button/frame traffic, all compared against a time-of-day model.
module tb_p03_time_set_ctrl;

  localparam int TPS = 4;
  localparam int BF  = 2;
  localparam int TOF = 5;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  p03_time_set_ctrl_if bus_if ();

  p03_time_set_ctrl #(
    .TICKS_PER_SEC  (TPS),
    .BLINK_FRAMES   (BF),
    .TIMEOUT_FRAMES (TOF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: time of day as integers plus edit-mode bookkeeping.
  int m_h, m_m, m_s, m_presc, m_mode, m_to, m_bc;
  bit m_ph, m_mtick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_h = 0; m_m = 0; m_s = 0; m_presc = 0; m_mode = 0;
    m_to = 0; m_bc = 0; m_ph = 0; m_mtick = 0;
  endfunction

  function automatic void model_step(input bit mp, input bit ip, input bit fs);
    int  nmode, total;
    bit  entry;
    m_mtick = 0;
    if (m_mode == 0) begin
      if (m_presc == TPS - 1) begin
        m_presc = 0;
        total   = (m_h * 3600 + m_m * 60 + m_s + 1) % 86400;
        if ((total / 60) % 60 != m_m) m_mtick = 1;
        m_h = total / 3600;
        m_m = (total / 60) % 60;
        m_s = total % 60;
      end else begin
        m_presc++;
      end
    end else if (ip && !mp) begin
      case (m_mode)
        1: m_h = (m_h + 1) % 24;
        2: begin m_m = (m_m + 1) % 60; m_mtick = 1; end
        default: begin m_s = 0; m_presc = 0; end
      endcase
    end
    nmode = m_mode;
    if (mp) nmode = (m_mode + 1) % 4;
    else if (m_mode != 0 && fs && m_to == TOF - 1) nmode = 0;
    entry = (nmode != m_mode);
    if (mp || ip || entry) m_to = 0;
    else if (m_mode != 0 && fs) m_to++;
    if (ip || entry) begin
      m_bc = 0; m_ph = 0;
    end else if (fs) begin
      m_bc++;
      if (m_bc == BF) begin m_bc = 0; m_ph = !m_ph; end
    end
    m_mode = nmode;
  endfunction

  function automatic logic [31:0] exp_state();
    int         hh;
    logic [2:0] mask;
`ifdef TWELVE_HOUR_EN
    hh = (m_h % 12 == 0) ? 12 : m_h % 12;
`else
    hh = m_h;
`endif
    mask = (m_mode == 0 || !m_ph) ? 3'b000 : 3'(1 << (3 - m_mode));
    return {6'd0, 2'(hh / 10), 4'(hh % 10), 3'(m_m / 10), 4'(m_m % 10),
            3'(m_s / 10), 4'(m_s % 10), mask, 2'(m_mode), m_mtick};
  endfunction

  function automatic logic [31:0] dut_state();
    return {6'd0, bus_if.hrs_d, bus_if.hrs_u, bus_if.min_d, bus_if.min_u,
            bus_if.sec_d, bus_if.sec_u, bus_if.blank_mask, bus_if.mode,
            bus_if.minute_tick};
  endfunction

  function automatic int dut_secs();
    return int'(bus_if.sec_d) * 10 + int'(bus_if.sec_u);
  endfunction

  // One clock: drive inputs, let the edge happen, advance the model, compare.
  task automatic cycle(input bit mp, input bit ip, input bit fs);
    bus_if.mode_pulse  = mp;
    bus_if.inc_pulse   = ip;
    bus_if.frame_start = fs;
    @(posedge clk);
    model_step(mp, ip, fs);
    @(negedge clk);
    check("cycle", dut_state(), exp_state());
    bus_if.mode_pulse  = 1'b0;
    bus_if.inc_pulse   = 1'b0;
    bus_if.frame_start = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  guard, frames, held;
    bool_hit: begin end
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    bus_if.mode_pulse  = 1'b0;
    bus_if.inc_pulse   = 1'b0;
    bus_if.frame_start = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset", dut_state(), 32'd0);
    reset = 1'b0;

    // Run until seconds read 59 just after a tick.
    guard = 0;
    while (!(m_s == 59 && m_presc == 0) && guard < 400) begin
      cycle(0, 0, 0);
      guard++;
    end
    check("reach_59s", 32'(m_s), 32'd59);

    // Preload 23:59 through the SET modes, seconds stay at 59.
    cycle(1, 0, 0);
    guard = 0;
    while (m_h != 23 && guard < 30) begin cycle(0, 1, 0); guard++; end
    cycle(1, 0, 0);
    guard = 0;
    while (m_m != 59 && guard < 70) begin cycle(0, 1, 0); guard++; end
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    check("preload", dut_state() >> 6, 32'({2'd2, 4'd3, 3'd5, 4'd9, 3'd5, 4'd9}));

    // Full-day rollover resolves in a single step.
    guard = 0;
    while (!(m_h == 0 && m_m == 0 && m_s == 0) && guard < 8) begin
      cycle(0, 0, 0);
      guard++;
    end
    check("rollover_time", dut_state() >> 6, 32'd0);
    check("rollover_mtick", 32'(bus_if.minute_tick), 32'd1);
    cycle(0, 0, 0);
    check("mtick_one_cycle", 32'(bus_if.minute_tick), 32'd0);

    // SET_HRS: 25 increments wrap mod 24; time is frozen.
    cycle(1, 0, 0);
    held = m_s;
    repeat (25) cycle(0, 1, 0);
    check("hrs_after_25", 32'({bus_if.hrs_d, bus_if.hrs_u}), 32'h01);
    check("mode_set_hrs", 32'(bus_if.mode), 32'd1);
    repeat (100) cycle(0, 0, 0);
    check("frozen_secs", 32'(dut_secs()), 32'(held));

    // SET_MIN: 59 -> 00 without hour carry, then mode beats inc.
    cycle(1, 0, 0);
    guard = 0;
    while (m_m != 59 && guard < 70) begin cycle(0, 1, 0); guard++; end
    cycle(0, 1, 0);
    check("min_wrap", 32'({bus_if.min_d, bus_if.min_u}), 32'h00);
    check("min_wrap_hrs", 32'({bus_if.hrs_d, bus_if.hrs_u}), 32'h01);
    check("min_wrap_mtick", 32'(bus_if.minute_tick), 32'd1);
    cycle(1, 1, 0);
    check("mode_wins", 32'(bus_if.mode), 32'd3);
    check("mode_wins_min", 32'({bus_if.min_d, bus_if.min_u}), 32'h00);

    // Blink in SET_MIN with a frame every 8 cycles.
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    cycle(1, 0, 0);
    for (int i = 0; i < 16; i++) begin
      cycle(0, 0, (i % 8) == 7);
      if (i == 7) check("blink_1frame", 32'(bus_if.blank_mask), 32'b000);
    end
    check("blink_2frames", 32'(bus_if.blank_mask), 32'b010);
    cycle(0, 1, 0);
    check("blink_inc_clear", 32'(bus_if.blank_mask), 32'b000);
    for (int i = 0; i < 16; i++) cycle(0, 0, (i % 8) == 7);
    check("blink_again", 32'(bus_if.blank_mask), 32'b010);

    // SET_SEC idle timeout after TOF frames, then seconds resume.
    cycle(1, 0, 0);
    frames = 0;
    for (int i = 0; i < 100; i++) begin
      cycle(0, 0, (i % 8) == 7);
      if ((i % 8) == 7) frames++;
      if (bus_if.mode == 2'd0) break;
    end
    check("timeout_frames", 32'(frames), 32'(TOF));
    check("timeout_mode", 32'(bus_if.mode), 32'd0);
    held = m_s;
    repeat (12) cycle(0, 0, 0);
    check("secs_resume", 32'(dut_secs() != held), 32'd1);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      cycle($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0,
            $urandom_range(0, 7) == 0);
    end

    // Asynchronous reset mid-count takes effect before the next edge.
    guard = 0;
    while ((m_mode != 0 || dut_state() >> 6 == 32'd0) && guard < 200) begin
      cycle(m_mode != 0, 0, 0);
      guard++;
    end
    repeat (3) cycle(0, 0, 0);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", dut_state(), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (10) cycle(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
